// File: rtl/mic1_mem_pkg.sv
// Shared types and default widths for the MIC-1 main-memory arbiter.
//   mem_req_id_t : identifies which requester owns a port A access
//   mem_cmd_t    : one port A command (write flag, word address, write data)
//                  at the default widths
package mic1_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } mem_req_id_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter for port A of main memory.
//   clk, rst_n   : clock, synchronous active-low reset
//   req[1:0]     : raw requests, bit 0 = CPU, bit 1 = debug port
//   busy[1:0]    : requester was granted last cycle; its held req is that
//                  same access, so it is not eligible again yet
//   grant_valid  : a requester wins this cycle (combinational)
//   grant_id     : which requester wins
// RR_EN=1 alternates when both are eligible; RR_EN=0 gives the CPU fixed
// priority and lets the debug port in only while cpu req is low.
module rr_arbiter2
    import mic1_mem_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  busy,
    output logic        grant_valid,
    output mem_req_id_t grant_id
);

    logic [1:0]  eligible;
    mem_req_id_t last_id;

    assign eligible = req & ~busy;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_CPU;
        if (RR_EN) begin
            if (eligible == 2'b11) begin
                grant_valid = 1'b1;
                grant_id    = (last_id == REQ_CPU) ? REQ_DBG : REQ_CPU;
            end else if (eligible[0]) begin
                grant_valid = 1'b1;
                grant_id    = REQ_CPU;
            end else if (eligible[1]) begin
                grant_valid = 1'b1;
                grant_id    = REQ_DBG;
            end
        end else begin
            if (eligible[0]) begin
                grant_valid = 1'b1;
                grant_id    = REQ_CPU;
            end else if (eligible[1] && !req[0]) begin
                // A CPU request that is merely waiting out its own grant
                // still blocks the debug port in fixed-priority mode.
                grant_valid = 1'b1;
                grant_id    = REQ_DBG;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge inside the same always_ff,
    // and all state here uses non-blocking assignments.
    // Pointer starts as "last = debug" so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id <= REQ_DBG;
        end else if (grant_valid) begin
            last_id <= grant_id;
        end
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Shares main_memory port A between the MIC-1 datapath (CPU, MAR/MDR) and
// the program-load/debug port, and sequences MBR byte fetches on port B.
//   clk, rst_n                   : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata        : CPU word access, held until cpu_gnt
//   cpu_gnt, cpu_rvalid          : command issued / read data is for CPU
//   dbg_*                        : same set for the debug requester
//   fetch_req, fetch_addr        : one-cycle MBR byte fetch request
//   fetch_rvalid                 : port B read data valid (load MBR)
//   mem_wen_A/ren_A/addr_A/wdata_A : registered port A command
//   mem_ren_B, mem_addr_B        : registered port B command; addr held
//                                  until the next fetch is issued
// Port A: req sampled at N, command + gnt at N+1, rvalid at N+2 (reads).
// Port B: fetch_req at N, ren/addr at N+1, fetch_rvalid at N+2.
module main_memory_arbiter
    import mic1_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_rvalid,
    output logic              mem_wen_A,
    output logic              mem_ren_A,
    output logic [ADDR_W-1:0] mem_addr_A,
    output logic [DATA_W-1:0] mem_wdata_A,
    output logic              mem_ren_B,
    output logic [ADDR_W-1:0] mem_addr_B
);

    // Command record at this instance's widths.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic        grant_valid;
    mem_req_id_t grant_id;
    mem_req_id_t rd_owner;
    cmd_t        cpu_cmd;
    cmd_t        dbg_cmd;
    cmd_t        win_cmd;

    assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign dbg_cmd = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
    assign win_cmd = (grant_id == REQ_DBG) ? dbg_cmd : cpu_cmd;

    // A grant pulse consumes the request: the requester is masked for the
    // cycle its gnt is high, so a req still held then is not re-granted.
    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         ({dbg_req, cpu_req}),
        .busy        ({dbg_gnt, cpu_gnt}),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_gnt      <= 1'b0;
            dbg_gnt      <= 1'b0;
            cpu_rvalid   <= 1'b0;
            dbg_rvalid   <= 1'b0;
            mem_wen_A    <= 1'b0;
            mem_ren_A    <= 1'b0;
            mem_addr_A   <= '0;
            mem_wdata_A  <= '0;
            rd_owner     <= REQ_CPU;
            mem_ren_B    <= 1'b0;
            mem_addr_B   <= '0;
            fetch_rvalid <= 1'b0;
        end else begin
            // Port A issue stage
            cpu_gnt   <= grant_valid && (grant_id == REQ_CPU);
            dbg_gnt   <= grant_valid && (grant_id == REQ_DBG);
            mem_ren_A <= grant_valid && !win_cmd.we;
            mem_wen_A <= grant_valid &&  win_cmd.we;
            if (grant_valid) begin
                mem_addr_A  <= win_cmd.addr;
                mem_wdata_A <= win_cmd.wdata;
                rd_owner    <= grant_id;
            end

            // Port A return stage: the owner tag travels with the read, so a
            // different winner on the next cycle cannot steal the rvalid.
            cpu_rvalid <= mem_ren_A && (rd_owner == REQ_CPU);
            dbg_rvalid <= mem_ren_A && (rd_owner == REQ_DBG);

            // Port B: independent of port A; address held between fetches.
            mem_ren_B <= fetch_req;
            if (fetch_req) begin
                mem_addr_B <= fetch_addr;
            end
            fetch_rvalid <= mem_ren_B;
        end
    end

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter. A round-robin instance (dut) is
// wired to a small main_memory model (word port A, byte port B); a second
// fixed-priority instance (dut_fp) sees the same stimulus for grant checks.
module tb_main_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;

    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, fetch_rvalid;
    logic        mem_wen_A, mem_ren_A, mem_ren_B;
    logic [31:0] mem_addr_A, mem_wdata_A, mem_addr_B;

    logic        fp_cpu_gnt, fp_cpu_rvalid, fp_dbg_gnt, fp_dbg_rvalid, fp_fetch_rvalid;
    logic        fp_mem_wen_A, fp_mem_ren_A, fp_mem_ren_B;
    logic [31:0] fp_mem_addr_A, fp_mem_wdata_A, fp_mem_addr_B;

    logic [31:0] mem [0:63];
    logic [31:0] rdata_a = '0;
    logic [7:0]  mbr = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    main_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rvalid(fetch_rvalid),
        .mem_wen_A(mem_wen_A), .mem_ren_A(mem_ren_A), .mem_addr_A(mem_addr_A),
        .mem_wdata_A(mem_wdata_A), .mem_ren_B(mem_ren_B), .mem_addr_B(mem_addr_B)
    );

    main_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(fp_cpu_gnt), .cpu_rvalid(fp_cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(fp_dbg_gnt), .dbg_rvalid(fp_dbg_rvalid),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rvalid(fp_fetch_rvalid),
        .mem_wen_A(fp_mem_wen_A), .mem_ren_A(fp_mem_ren_A), .mem_addr_A(fp_mem_addr_A),
        .mem_wdata_A(fp_mem_wdata_A), .mem_ren_B(fp_mem_ren_B), .mem_addr_B(fp_mem_addr_B)
    );

    // main_memory model: synchronous read on both ports; port B latches the
    // byte address with the read and returns the selected byte.
    always @(posedge clk) begin
        if (mem_wen_A) mem[mem_addr_A[5:0]] <= mem_wdata_A;
        if (mem_ren_A) rdata_a <= mem[mem_addr_A[5:0]];
        if (mem_ren_B) mbr <= 8'(mem[mem_addr_B[7:2]] >> {mem_addr_B[1:0], 3'b000});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {24'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid,
                mem_ren_A, mem_wen_A, mem_ren_B, fetch_rvalid};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;
        mem[3] = 32'hDEAD_BEEF;
        mem[7] = 32'hAABB_CCDD;

        // Reset held 5 cycles with every request high
        rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 32'd3; dbg_req = 1'b1; dbg_addr = 32'd2;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("reset_strobes_%0d", i), strobes(), 32'h0);
        end
        check("reset_addr_A", mem_addr_A, 32'h0);
        check("reset_addr_B", mem_addr_B, 32'h0);
        rst_n = 1'b1;
        tick();
        check("release_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("release_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        check("release_fp_cpu_gnt", {31'd0, fp_cpu_gnt}, 32'd1);
        cpu_req = 1'b0; dbg_req = 1'b0; fetch_req = 1'b0;
        tick();
        check("release_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        tick();

        // CPU read of word 3
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd3;
        tick();
        check("rd3_gnt", {31'd0, cpu_gnt}, 32'd1);
        check("rd3_ren_wen", {30'd0, mem_ren_A, mem_wen_A}, 32'b10);
        check("rd3_addr", mem_addr_A, 32'd3);
        check("rd3_no_rvalid_yet", {31'd0, cpu_rvalid}, 32'd0);
        cpu_req = 1'b0;
        tick();
        check("rd3_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b10);
        check("rd3_data", rdata_a, 32'hDEAD_BEEF);
        check("rd3_gnt_dropped", {31'd0, cpu_gnt}, 32'd0);
        tick();

        // Both requesters held 4 cycles; reset first so the CPU wins the tie
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'd1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd2;
        tick();
        check("rr1_gnts", {30'd0, cpu_gnt, dbg_gnt}, 32'b10);
        check("fp1_gnts", {30'd0, fp_cpu_gnt, fp_dbg_gnt}, 32'b10);
        tick();
        check("rr2_gnts", {30'd0, cpu_gnt, dbg_gnt}, 32'b01);
        check("fp2_gnts", {30'd0, fp_cpu_gnt, fp_dbg_gnt}, 32'b00);
        check("rr2_cpu_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b10);
        check("rr2_data", rdata_a, 32'h1111_1111);
        tick();
        check("rr3_gnts", {30'd0, cpu_gnt, dbg_gnt}, 32'b10);
        check("fp3_gnts", {30'd0, fp_cpu_gnt, fp_dbg_gnt}, 32'b10);
        check("rr3_dbg_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b01);
        check("rr3_data", rdata_a, 32'h2222_2222);
        tick();
        check("rr4_gnts", {30'd0, cpu_gnt, dbg_gnt}, 32'b01);
        check("fp4_gnts", {30'd0, fp_cpu_gnt, fp_dbg_gnt}, 32'b00);
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick();
        tick();
        tick();

        // MBR fetches of the four bytes of word 7 (0xAABBCCDD)
        fetch_req = 1'b1; fetch_addr = 32'h1C;
        tick();
        check("f0_ren_B", {31'd0, mem_ren_B}, 32'd1);
        check("f0_addr_B", mem_addr_B, 32'h1C);
        fetch_addr = 32'h1D;
        tick();
        check("f1_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        check("f1_mbr", {24'd0, mbr}, 32'hDD);
        check("f1_addr_B", mem_addr_B, 32'h1D);
        fetch_addr = 32'h1E;
        tick();
        check("f2_mbr", {24'd0, mbr}, 32'hCC);
        fetch_addr = 32'h1F;
        tick();
        check("f3_mbr", {24'd0, mbr}, 32'hBB);
        fetch_req = 1'b0; fetch_addr = 32'h0;
        tick();
        check("f4_rvalid", {31'd0, fetch_rvalid}, 32'd1);
        check("f4_mbr", {24'd0, mbr}, 32'hAA);
        tick();
        check("f5_rvalid_done", {31'd0, fetch_rvalid}, 32'd0);
        check("f5_addr_B_held", mem_addr_B, 32'h1F);

        // Debug write to word 7, then CPU read of word 7
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd7; dbg_wdata = 32'h1234_5678;
        tick();
        check("wr7_dbg_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'b01);
        check("wr7_ren_wen", {30'd0, mem_ren_A, mem_wen_A}, 32'b01);
        check("wr7_wdata", mem_wdata_A, 32'h1234_5678);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7;
        tick();
        check("rd7_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'b10);
        check("wr7_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b00);
        cpu_req = 1'b0;
        tick();
        check("rd7_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'b10);
        check("rd7_data", rdata_a, 32'h1234_5678);
        tick();

        // Reset asserted the cycle after a CPU read grant
        cpu_req = 1'b1; cpu_addr = 32'd3;
        tick();
        check("rst_mid_gnt", {31'd0, cpu_gnt}, 32'd1);
        rst_n = 1'b0; cpu_req = 1'b0;
        tick();
        check("rst_mid_strobes", strobes(), 32'h0);
        check("rst_mid_addr_A", mem_addr_A, 32'h0);
        rst_n = 1'b1;
        tick();
        check("rst_mid_idle1", strobes(), 32'h0);
        tick();
        check("rst_mid_idle2", strobes(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
